// File: rtl/sr_pkg.sv
// Shared definitions for the AstroPix 2 configuration shift-register blocks.
package sr_pkg;

    localparam int SR_WORD_WIDTH = 64;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        WAIT_DATA = 4'd2,
        SETUP     = 4'd3,
        CK1       = 4'd4,
        GAP1      = 4'd5,
        CK2       = 4'd6,
        GAP2      = 4'd7,
        LOAD      = 4'd8,
        DONE      = 4'd9
    } sr_wr_state_t;

    // States whose duration is governed by the phase timer
    function automatic logic is_timed_state(input sr_wr_state_t s);
        logic r;
        case (s)
            SETUP, CK1, GAP1, CK2, GAP2, LOAD: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter that measures one SR phase of load_val+1 clocks.
module sr_phase_timer #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] cnt_r;

    // Reload at phase entry, otherwise count down and park at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {DIV_WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {DIV_WIDTH{1'b0}}) begin
            cnt_r <= cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Last cycle of the current phase
    assign tc = (cnt_r == {DIV_WIDTH{1'b0}});

endmodule

// File: rtl/sr_config_writer.sv
// Transmit side of the AstroPix 2 config shift register: pulls 64-bit words
// from a FIFO and shifts them MSB-first with two-phase non-overlapping clocks.
module sr_config_writer
    import sr_pkg::*;
#(
    parameter int WORD_WIDTH = SR_WORD_WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  n_bits,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [WORD_WIDTH-1:0] cfg_fifo_data,
    input  logic                  cfg_fifo_empty,
    output logic                  cfg_fifo_rd_en,
    output logic                  cfg_fifo_clock,
    output logic                  sr_ck1,
    output logic                  sr_ck2,
    output logic                  sr_sin,
    output logic                  sr_ld,
    output logic                  busy,
    output logic                  done
);

    localparam int WORD_IDX_W = $clog2(WORD_WIDTH);

    sr_wr_state_t          state_r;
    logic [CNT_WIDTH-1:0]  n_bits_r;
    logic [CNT_WIDTH-1:0]  bit_cnt_r;
    logic [CNT_WIDTH-1:0]  bit_cnt_nxt_s;
    logic [DIV_WIDTH-1:0]  div_r;
    logic [DIV_WIDTH-1:0]  timer_val_s;
    logic [WORD_WIDTH-1:0] sreg_r;
    logic                  timer_load_s;
    logic                  phase_tc_s;
    logic                  word_end_s;

    assign cfg_fifo_clock = clock;
    assign bit_cnt_nxt_s  = bit_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign word_end_s     = (bit_cnt_nxt_s[WORD_IDX_W-1:0] == {WORD_IDX_W{1'b0}});

    // Timer reloads on every cycle outside timed phases and at each phase end;
    // the start cycle uses the live clk_div because div_r is not latched yet
    always_comb begin
        timer_load_s = 1'b1;
        timer_val_s  = div_r;
        if (is_timed_state(state_r)) begin
            timer_load_s = phase_tc_s;
        end else begin
            timer_load_s = 1'b1;
        end
        if (state_r == IDLE) begin
            timer_val_s = clk_div;
        end else begin
            timer_val_s = div_r;
        end
    end

    sr_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .tc       (phase_tc_s)
    );

    // Transfer FSM; every SR pin is set on the edge that enters its phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            n_bits_r       <= {CNT_WIDTH{1'b0}};
            bit_cnt_r      <= {CNT_WIDTH{1'b0}};
            div_r          <= {DIV_WIDTH{1'b0}};
            sreg_r         <= {WORD_WIDTH{1'b0}};
            cfg_fifo_rd_en <= 1'b0;
            sr_ck1         <= 1'b0;
            sr_ck2         <= 1'b0;
            sr_sin         <= 1'b0;
            sr_ld          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (abort && (state_r != IDLE) && (state_r != DONE)) begin
            // Abort drops any pending FIFO read and skips the load strobe
            state_r        <= DONE;
            cfg_fifo_rd_en <= 1'b0;
            sr_ck1         <= 1'b0;
            sr_ck2         <= 1'b0;
            sr_sin         <= 1'b0;
            sr_ld          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        n_bits_r  <= n_bits;
                        div_r     <= clk_div;
                        bit_cnt_r <= {CNT_WIDTH{1'b0}};
                        busy      <= 1'b1;
                        if (n_bits == {CNT_WIDTH{1'b0}}) begin
                            sr_ld   <= 1'b1;
                            state_r <= LOAD;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (!cfg_fifo_empty) begin
                        cfg_fifo_rd_en <= 1'b1;
                        state_r        <= WAIT_DATA;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                WAIT_DATA: begin
                    // First cycle carries the strobe, second cycle has the data
                    if (cfg_fifo_rd_en) begin
                        cfg_fifo_rd_en <= 1'b0;
                    end else begin
                        sreg_r  <= cfg_fifo_data;
                        sr_sin  <= cfg_fifo_data[WORD_WIDTH-1];
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_tc_s) begin
                        sr_ck1  <= 1'b1;
                        state_r <= CK1;
                    end
                end
                CK1: begin
                    if (phase_tc_s) begin
                        sr_ck1  <= 1'b0;
                        state_r <= GAP1;
                    end
                end
                GAP1: begin
                    if (phase_tc_s) begin
                        sr_ck2  <= 1'b1;
                        state_r <= CK2;
                    end
                end
                CK2: begin
                    if (phase_tc_s) begin
                        sr_ck2  <= 1'b0;
                        state_r <= GAP2;
                    end
                end
                GAP2: begin
                    if (phase_tc_s) begin
                        bit_cnt_r <= bit_cnt_nxt_s;
                        sreg_r    <= {sreg_r[WORD_WIDTH-2:0], 1'b0};
                        if (bit_cnt_nxt_s == n_bits_r) begin
                            sr_ld   <= 1'b1;
                            state_r <= LOAD;
                        end else if (word_end_s) begin
                            state_r <= FETCH;
                        end else begin
                            sr_sin  <= sreg_r[WORD_WIDTH-2];
                            state_r <= SETUP;
                        end
                    end
                end
                LOAD: begin
                    if (phase_tc_s) begin
                        sr_ld   <= 1'b0;
                        sr_sin  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cfg_fifo_rd_en <= 1'b0;
                    sr_ck1         <= 1'b0;
                    sr_ck2         <= 1'b0;
                    sr_sin         <= 1'b0;
                    sr_ld          <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_config_writer.sv
// Directed bench for sr_config_writer with a FIFO model and an SR receiver monitor.
module tb_sr_config_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] n_bits = 16'd0;
    logic [7:0]  clk_div = 8'd0;
    logic [63:0] fifo_dout = 64'd0;
    logic        cfg_fifo_empty;
    logic        cfg_fifo_rd_en, cfg_fifo_clock;
    logic        sr_ck1, sr_ck2, sr_sin, sr_ld, busy, done;

    int n_asserts = 0;
    int n_fail = 0;

    // FIFO model: written by the stimulus, popped one cycle after rd_en
    logic [63:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign cfg_fifo_empty = (wr_ptr == rd_ptr);

    always #5 clock = ~clock;

    sr_config_writer dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .n_bits         (n_bits),
        .clk_div        (clk_div),
        .cfg_fifo_data  (fifo_dout),
        .cfg_fifo_empty (cfg_fifo_empty),
        .cfg_fifo_rd_en (cfg_fifo_rd_en),
        .cfg_fifo_clock (cfg_fifo_clock),
        .sr_ck1         (sr_ck1),
        .sr_ck2         (sr_ck2),
        .sr_sin         (sr_sin),
        .sr_ld          (sr_ld),
        .busy           (busy),
        .done           (done)
    );

    // FIFO read port
    always @(posedge clock) begin
        if (cfg_fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= fifo_mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Receiver monitor: running totals, sampled on the falling system clock
    int ck1_rise = 0, ck2_rise = 0, ck1_w = 0, ck2_w = 0, w1_err = 0, w2_err = 0;
    int ld_rise = 0, ld_w = 0, last_ld_w = 0, done_tot = 0, rd_tot = 0, rd_empty_err = 0;
    int overlap = 0, sin_err = 0, adj_err = 0, rx_idx = 0, exp_w = 1;
    logic [63:0] rx_word = 64'd0;
    logic        rx_bit [0:4095];
    logic        p_ck1 = 1'b0, p_ck2 = 1'b0, p_ld = 1'b0, p_sin = 1'b0;

    always @(negedge clock) begin
        if (sr_ck1 && !p_ck1) begin
            ck1_rise <= ck1_rise + 1;
            rx_bit[rx_idx % 4096] <= sr_sin;
            rx_idx <= rx_idx + 1;
            rx_word <= {rx_word[62:0], sr_sin};
            if (p_ck2) adj_err <= adj_err + 1;
        end
        if (sr_ck2 && !p_ck2) begin
            ck2_rise <= ck2_rise + 1;
            if (p_ck1) adj_err <= adj_err + 1;
        end
        if (sr_ck1) ck1_w <= p_ck1 ? ck1_w + 1 : 1;
        if (!sr_ck1 && p_ck1 && ck1_w != exp_w) w1_err <= w1_err + 1;
        if (sr_ck2) ck2_w <= p_ck2 ? ck2_w + 1 : 1;
        if (!sr_ck2 && p_ck2 && ck2_w != exp_w) w2_err <= w2_err + 1;
        if (sr_ld) ld_w <= p_ld ? ld_w + 1 : 1;
        if (sr_ld && !p_ld) ld_rise <= ld_rise + 1;
        if (!sr_ld && p_ld) last_ld_w <= ld_w;
        if (done) done_tot <= done_tot + 1;
        if (cfg_fifo_rd_en) rd_tot <= rd_tot + 1;
        if (cfg_fifo_rd_en && cfg_fifo_empty) rd_empty_err <= rd_empty_err + 1;
        if (sr_ck1 && sr_ck2) overlap <= overlap + 1;
        if ((sr_ck1 || sr_ck2) && (sr_sin != p_sin)) sin_err <= sin_err + 1;
        p_ck1 <= sr_ck1;
        p_ck2 <= sr_ck2;
        p_ld  <= sr_ld;
        p_sin <= sr_sin;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_start(input int nb, input int dv);
        n_bits  = nb[15:0];
        clk_div = dv[7:0];
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    function automatic logic [63:0] pins();
        return {57'd0, sr_ck1, sr_ck2, sr_sin, sr_ld, cfg_fifo_rd_en, busy, done};
    endfunction

    int s_c1, s_c2, s_ld, s_rd, s_dn, s_w, s_ov, s_sn, s_ad, s_re, s_idx;

    task automatic snap();
        s_c1 = ck1_rise; s_c2 = ck2_rise; s_ld = ld_rise; s_rd = rd_tot;
        s_dn = done_tot; s_w = w1_err + w2_err; s_ov = overlap; s_sn = sin_err;
        s_ad = adj_err; s_re = rd_empty_err; s_idx = rx_idx;
    endtask

    logic [63:0] acc;
    logic [63:0] exp_words [0:7];
    int nb, dv, k, mism;
    logic seen;

    initial begin
        // Reset state
        step();
        chk("reset_pins", pins(), 64'd0);
        chk("fifo_clock_low", {63'd0, cfg_fifo_clock}, 64'd0);
        reset = 1'b0;
        step();

        // Single word, clk_div=1
        exp_w = 2;
        push(64'hA5A5_0000_FFFF_1234);
        snap();
        do_start(64, 1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(64 * 5 * 2 + 60, "t1_done_seen");
        chk("t1_busy_at_done", {63'd0, busy}, 64'd0);
        chk("t1_ck1_pulses", ck1_rise - s_c1, 64);
        chk("t1_ck2_pulses", ck2_rise - s_c2, 64);
        chk("t1_rx_word", rx_word, 64'hA5A5_0000_FFFF_1234);
        chk("t1_ld_pulses", ld_rise - s_ld, 1);
        chk("t1_ld_width", last_ld_w, 2);
        chk("t1_rd_en", rd_tot - s_rd, 1);
        chk("t1_width_err", w1_err + w2_err - s_w, 0);
        step();
        chk("t1_done_one_cycle", {63'd0, done}, 64'd0);
        chk("t1_done_count", done_tot - s_dn, 1);

        // Multi-word partial transfer, clk_div=0
        exp_w = 1;
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'h8000_0000_0000_0000);
        snap();
        do_start(100, 0);
        wait_done(100 * 5 + 60, "t2_done_seen");
        chk("t2_ck1_pulses", ck1_rise - s_c1, 100);
        chk("t2_rd_en", rd_tot - s_rd, 2);
        acc = 64'd0;
        for (int i = 0; i < 64; i++) acc = {acc[62:0], rx_bit[(s_idx + i) % 4096]};
        chk("t2_word0_bits", acc, 64'hFFFF_FFFF_FFFF_FFFF);
        acc = 64'd0;
        for (int i = 64; i < 100; i++) acc = {acc[62:0], rx_bit[(s_idx + i) % 4096]};
        chk("t2_tail_bits", acc, 64'h0000_0008_0000_0000);
        chk("t2_fifo_empty", {63'd0, cfg_fifo_empty}, 64'd1);
        step();

        // Empty FIFO stall for 50 clocks
        snap();
        do_start(8, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            seen = seen | sr_ck1 | sr_ck2;
        end
        chk("t3_stall_clocks", {63'd0, seen}, 64'd0);
        chk("t3_stall_busy", {63'd0, busy}, 64'd1);
        chk("t3_stall_rd_en", rd_tot - s_rd, 0);
        push(64'h3C00_0000_0000_0000);
        wait_done(200, "t3_done_seen");
        chk("t3_ck1_pulses", ck1_rise - s_c1, 8);
        chk("t3_rx_bits", {56'd0, rx_word[7:0]}, 64'h3C);
        chk("t3_rd_en", rd_tot - s_rd, 1);
        chk("t3_rd_while_empty", rd_empty_err - s_re, 0);
        step();

        // Abort beats start in the same cycle while idle
        abort = 1'b1;
        do_start(8, 0);
        abort = 1'b0;
        chk("t4_abort_over_start", {63'd0, busy}, 64'd0);

        // Abort in CK2 of bit 10
        exp_w = 2;
        push(64'h1234_5678_9ABC_DEF0);
        snap();
        do_start(64, 1);
        k = 0;
        while (!((ck2_rise - s_c2 == 10) && sr_ck2) && k < 500) begin
            step();
            k++;
        end
        chk("t4_reached_bit10", {63'd0, sr_ck2}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_ck2_dropped", {63'd0, sr_ck2}, 64'd0);
        chk("t4_done_pulse", {63'd0, done}, 64'd1);
        chk("t4_rx_bits", {54'd0, rx_word[9:0]}, 64'h048);
        step();
        step();
        chk("t4_done_count", done_tot - s_dn, 1);
        chk("t4_no_ld", ld_rise - s_ld, 0);
        chk("t4_idle_pins", pins(), 64'd0);
        exp_w = 3;
        push(64'hBEEF_0000_0000_0000);
        snap();
        do_start(16, 2);
        wait_done(16 * 5 * 3 + 60, "t4_restart_done");
        chk("t4_restart_rx", {48'd0, rx_word[15:0]}, 64'hBEEF);
        chk("t4_restart_ld_width", last_ld_w, 3);
        chk("t4_restart_width_err", w1_err + w2_err - s_w, 0);
        step();

        // Asynchronous reset in CK1 with clk_div=7
        exp_w = 8;
        push(64'hFFFF_0000_0000_0000);
        do_start(64, 7);
        k = 0;
        while (!sr_ck1 && k < 200) begin
            step();
            k++;
        end
        chk("t5_in_ck1", {63'd0, sr_ck1}, 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_reset_pins", pins(), 64'd0);
        step();
        reset = 1'b0;
        step();
        snap();
        do_start(0, 7);
        wait_done(50, "t5_done_seen");
        chk("t5_ld_pulses", ld_rise - s_ld, 1);
        chk("t5_ld_width", last_ld_w, 8);
        chk("t5_no_ck1", ck1_rise - s_c1, 0);
        chk("t5_no_rd_en", rd_tot - s_rd, 0);
        step();

        // Non-overlap sweep: widest phase first, then random sizes
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                nb = 2;
                dv = 255;
            end else begin
                nb = $urandom_range(1, 300);
                dv = $urandom_range(0, 255);
                if (nb * (dv + 1) > 2000) nb = 2000 / (dv + 1);
                if (nb < 1) nb = 1;
            end
            exp_w = dv + 1;
            for (int j = 0; j < (nb + 63) / 64; j++) begin
                exp_words[j] = {$urandom, $urandom};
                push(exp_words[j]);
            end
            snap();
            do_start(nb, dv);
            wait_done(nb * 5 * (dv + 1) + (dv + 1) + 100, "t6_done_seen");
            mism = 0;
            for (int i = 0; i < nb; i++) begin
                acc = exp_words[i / 64];
                if (rx_bit[(s_idx + i) % 4096] !== acc[63 - (i % 64)]) mism++;
            end
            chk("t6_bit_mismatches", mism, 0);
            chk("t6_ck1_pulses", ck1_rise - s_c1, nb);
            chk("t6_overlap", overlap - s_ov, 0);
            chk("t6_sin_unstable", sin_err - s_sn, 0);
            chk("t6_adjacent_clocks", adj_err - s_ad, 0);
            chk("t6_width_err", w1_err + w2_err - s_w, 0);
            chk("t6_ld_width", last_ld_w, dv + 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
